// File: rtl/soc_sysid_checker.sv
// Boot-time identity gate: reads the system-ID slave (ID word, timestamp word),
// compares against build-time constants, retries on mismatch or stall, and reports a verdict.
module soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h6603_8F82,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned RETRY_GAP    = 16,
  parameter int unsigned TIMEOUT      = 64,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic [2:0]  err_code,
  output logic [3:0]  retry_cnt,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  typedef enum logic [3:0] {
    IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, GAP, PASS, FAIL
  } state_e;

  localparam bit         HAS_LAT   = (READ_LATENCY != 0);
  localparam logic [1:0] LAT_LAST  = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST  = 8'(RETRY_GAP - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic        auto_q, auto_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  lat_q, lat_d;
  logic [7:0]  gap_q, gap_d;
  logic [3:0]  retry_q, retry_d;
  logic [2:0]  err_q, err_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic [31:0] cid_q, cid_d;
  logic [31:0] cts_q, cts_d;
  logic        av_read_q, av_addr_q, busy_q;
  logic [2:0]  verdict;
  logic        is_id;

  assign is_id = (state_q == RD_ID) || (state_q == LAT_ID);

  always_comb begin
    state_d = state_q;
    auto_d  = 1'b0;
    wait_d  = wait_q;
    lat_d   = lat_q;
    gap_d   = gap_q;
    retry_d = retry_q;
    err_d   = err_q;
    done_d  = done_q;
    ok_d    = ok_q;
    cid_d   = cid_q;
    cts_d   = cts_q;
    verdict = '0;
    case (state_q)
      IDLE, PASS, FAIL: begin
        if (start || auto_q) begin
          state_d = RD_ID;
          retry_d = '0;
          err_d   = '0;
          done_d  = 1'b0;
          ok_d    = 1'b0;
          wait_d  = '0;
        end
      end
      RD_ID, RD_TS: begin
        if (!av_waitrequest) begin
          wait_d = '0;
          lat_d  = '0;
          if (HAS_LAT) begin
            state_d = is_id ? LAT_ID : LAT_TS;
          end else begin
            if (is_id) cid_d = av_readdata;
            else       cts_d = av_readdata;
            state_d = is_id ? RD_TS : CHECK;
          end
        end else if (wait_q == TO_LAST) begin
          err_d[2] = 1'b1;
          wait_d   = '0;
          state_d  = CHECK;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      LAT_ID, LAT_TS: begin
        if (lat_q == LAT_LAST) begin
          if (is_id) cid_d = av_readdata;
          else       cts_d = av_readdata;
          state_d = is_id ? RD_TS : CHECK;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      CHECK: begin
        // A timed-out attempt captured nothing new, so only the timeout flag is reported.
        verdict = err_q[2] ? 3'b100
                           : {1'b0, cts_q != EXPECTED_TS, cid_q != EXPECTED_ID};
        err_d = verdict;
        if (verdict == 3'b000) begin
          state_d = PASS;
          done_d  = 1'b1;
          ok_d    = 1'b1;
        end else if (retry_q < RETRY_MAX) begin
          state_d = GAP;
          retry_d = retry_q + 4'd1;
          gap_d   = '0;
        end else begin
          state_d = FAIL;
          done_d  = 1'b1;
          ok_d    = 1'b0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = RD_ID;
          err_d   = '0;
          wait_d  = '0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      auto_q    <= AUTO_START;
      wait_q    <= '0;
      lat_q     <= '0;
      gap_q     <= '0;
      retry_q   <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      cid_q     <= '0;
      cts_q     <= '0;
      av_read_q <= 1'b0;
      av_addr_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      auto_q    <= auto_d;
      wait_q    <= wait_d;
      lat_q     <= lat_d;
      gap_q     <= gap_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      cid_q     <= cid_d;
      cts_q     <= cts_d;
      av_read_q <= (state_d == RD_ID) || (state_d == RD_TS);
      av_addr_q <= (state_d == RD_TS);
      busy_q    <= !((state_d == IDLE) || (state_d == PASS) || (state_d == FAIL));
    end
  end

  assign av_read     = av_read_q;
  assign av_address  = av_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = ok_q;
  assign err_code    = err_q;
  assign retry_cnt   = retry_q;
  assign captured_id = cid_q;
  assign captured_ts = cts_q;

endmodule

// File: doc/soc_sysid_checker.md
# soc_sysid_checker

Boot-time identity gate that sits directly downstream of the SoC system-ID slave. It drives that slave's control port as an Avalon-MM read master, fetches the ID word (address 0) and the timestamp word (address 1), and compares both against build-time constants. It retries on mismatch or stall, then reports pass/fail. Only on pass does `id_ok` release the LED counter and software-visible logic.

## Interface
- `EXPECTED_ID`: default 32'h0000_0000. Required word at address 0.
- `EXPECTED_TS`: default 32'h6603_8F82. Required word at address 1.
- `READ_LATENCY`: default 0, legal 0..3. Fixed slave read latency in cycles.
- `MAX_RETRIES`: default 3, legal 0..15. Extra attempts after the first failed one.
- `RETRY_GAP`: default 16, legal 1..255. Idle cycles between attempts.
- `TIMEOUT`: default 64, legal 1..255. Maximum cycles `av_waitrequest` may stall one read.
- `AUTO_START`: default 1. 1 = run one check automatically after reset.

Ports:
- `clock`  in  1  Single clock; everything is synchronous to its rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `start`  in  1  One-cycle pulse that requests a check.
- `av_address`  out  1  Word address: 0 = ID, 1 = timestamp.
- `av_read`  out  1  Read strobe.
- `av_waitrequest`  in  1  Slave stall. Tie to 0 for a zero-wait slave.
- `av_readdata`  in  32  Read data.
- `busy`  out  1  A check is in progress.
- `done`  out  1  Sticky; a check has finished with a verdict.
- `id_ok`  out  1  Sticky; the last check passed.
- `err_code`  out  3  Sticky error flags of the last attempt: bit0 ID mismatch, bit1 timestamp mismatch, bit2 timeout.
- `retry_cnt`  out  4  Retries used in the current or last check.
- `captured_id`  out  32  Last word captured from address 0.
- `captured_ts`  out  32  Last word captured from address 1.

## Operation
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, GAP, PASS, FAIL.
- Reset forces IDLE. All outputs go to 0, and `captured_*` go to 0.
- IDLE → RD_ID when `start` is high, or on the first cycle after reset when `AUTO_START`=1. Entering RD_ID from IDLE, PASS or FAIL clears `retry_cnt`, `err_code`, `done` and `id_ok`.
- RD_ID: `av_read`=1, `av_address`=0. The read is accepted on the first cycle with `av_waitrequest`=0.
  - If `READ_LATENCY`=0, `av_readdata` is captured in that same cycle and the FSM goes to RD_TS.
  - Otherwise the FSM goes to LAT_ID, waits `READ_LATENCY` cycles with `av_read`=0, captures on the last of those cycles, then goes to RD_TS.
- RD_TS / LAT_TS: same as RD_ID / LAT_ID, with `av_address`=1 and capture into `captured_ts`.
- Stall timeout: a cycle counter runs while `av_read`=1 and `av_waitrequest`=1. When it reaches `TIMEOUT`, the FSM sets `err_code[2]`, deasserts `av_read` and goes to CHECK.
- CHECK sets `err_code[0]` = (`captured_id` ≠ `EXPECTED_ID`) and `err_code[1]` = (`captured_ts` ≠ `EXPECTED_TS`).
  - All three error bits 0 → PASS.
  - Otherwise, if `retry_cnt` < `MAX_RETRIES` → GAP and `retry_cnt`+1.
  - Otherwise → FAIL.
- GAP idles `RETRY_GAP` cycles. It then clears `err_code` and goes to RD_ID.
- PASS sets `id_ok`=1 and `done`=1. FAIL sets `id_ok`=0 and `done`=1. Both hold until `start` or `reset`.
- `busy`=1 in every state except IDLE, PASS and FAIL.
- `start` is ignored while `busy`=1.
- `av_read` is never asserted in IDLE, GAP, CHECK, PASS, FAIL or the LAT states.

## Timing
- All outputs are registered or decoded from the registered state. There is no combinational path from `av_readdata` to any output.
- Cycle numbering for `READ_LATENCY`=0, `av_waitrequest`=0, with edge 1 the first edge after `reset` falls:
  - edge 1: IDLE → RD_ID.
  - edge 2: ID captured, → RD_TS.
  - edge 3: timestamp captured, → CHECK.
  - edge 4: → PASS.
  - `id_ok` is visible after edge 4.
- Each unit of `READ_LATENCY` adds one cycle per read.
- Each stalled cycle adds one cycle, capped at `TIMEOUT`.
- `av_address` and `av_read` stay stable for as long as `av_waitrequest`=1.
- A `start` pulse in the same cycle as `reset` is discarded.
- Reset mid-read abandons the transaction; `av_read`=0 on the next cycle.
- A `start` pulse in PASS or FAIL is handled like IDLE → RD_ID, one cycle later.

## Test plan
- Nominal run: slave returns 0x00000000 then 0x66038F82 with `READ_LATENCY`=0 → `id_ok`=1, `done`=1 after edge 4, `retry_cnt`=0, `err_code`=000.
- Bad timestamp on every read, `MAX_RETRIES`=3, `RETRY_GAP`=16 → 4 read pairs spaced 16 idle cycles apart, then FAIL with `err_code`=010, `retry_cnt`=3, `id_ok`=0.
- ID 0x12345678 on the first attempt and correct values on the second → PASS with `retry_cnt`=1, `captured_id`=0x00000000.
- `av_waitrequest` held high forever with `TIMEOUT`=64 → `av_read` drops after 64 stall cycles, `err_code`=100 is visible during GAP, and the final result is FAIL after 4 attempts.
- `READ_LATENCY`=2 with 3 stall cycles on each read → capture occurs exactly 2 cycles after acceptance, and PASS is reached at edge 14.
- Reset asserted during LAT_TS → next cycle is IDLE with all outputs 0. A later `start` pulse gives PASS within 4 edges.
